// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: alternates dark gaps and lit moles, scores hits,
// counts timeouts as misses and ends the game after MAX_MISS misses.
module mole_scheduler #(
    parameter int unsigned HOLD_TICKS = 800,
    parameter int unsigned GAP_TICKS  = 200,
    parameter int unsigned MAX_MISS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] rnd3,
    input  logic [7:0] keys,
    output logic       rnd_req,
    output logic [7:0] mole,
    output logic [7:0] score,
    output logic [3:0] miss,
    output logic       game_over
);

    typedef enum logic [1:0] {StIdle, StGap, StShow, StOver} state_e;

    localparam logic [9:0] GapLim  = 10'(GAP_TICKS);
    localparam logic [9:0] HoldLim = 10'(HOLD_TICKS);
    localparam logic [3:0] MissLim = 4'(MAX_MISS);

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0] hole_q, hole_d, last_q, last_d, pick;
    logic [7:0] score_d, mole_d;
    logic [3:0] miss_d, miss_inc;
    logic       rnd_req_d, game_over_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hole_d      = hole_q;
        last_d      = last_q;
        score_d     = score;
        miss_d      = miss;
        rnd_req_d   = 1'b0;
        // Counter saturates rather than wrapping.
        cnt_inc     = (cnt_q == 10'h3ff) ? cnt_q : cnt_q + 10'd1;
        pick        = (rnd3 == last_q) ? rnd3 + 3'd1 : rnd3;
        miss_inc    = miss + 4'd1;

        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d = StGap;
                    score_d = 8'd0;
                    miss_d  = 4'd0;
                    cnt_d   = 10'd0;
                    last_d  = 3'd0;
                end
            end
            StGap: begin
                if (tick) begin
                    if (cnt_inc == GapLim) begin
                        rnd_req_d = 1'b1;
                        hole_d    = pick;
                        last_d    = pick;
                        cnt_d     = 10'd0;
                        state_d   = StShow;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StShow: begin
                // A hit wins over a timeout landing in the same cycle.
                if (keys[hole_q]) begin
                    if (score != 8'hff) score_d = score + 8'd1;
                    cnt_d   = 10'd0;
                    state_d = StGap;
                end else if (tick) begin
                    if (cnt_inc == HoldLim) begin
                        miss_d  = miss_inc;
                        cnt_d   = 10'd0;
                        state_d = (miss_inc == MissLim) ? StOver : StGap;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: ;
        endcase

        // Lamp lights one cycle after entering SHOW and drops with the exit edge.
        mole_d      = (state_q == StShow && state_d == StShow) ? (8'b1 << hole_q) : 8'd0;
        game_over_d = (state_d == StOver);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 10'd0;
            hole_q    <= 3'd0;
            last_q    <= 3'd0;
            score     <= 8'd0;
            miss      <= 4'd0;
            mole      <= 8'd0;
            rnd_req   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hole_q    <= hole_d;
            last_q    <= last_d;
            score     <= score_d;
            miss      <= miss_d;
            mole      <= mole_d;
            rnd_req   <= rnd_req_d;
            game_over <= game_over_d;
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with short timings (GAP=2, HOLD=3, MAX_MISS=2).
module tb_mole_scheduler;

    logic       clk = 1'b0;
    logic       rst, tick, start;
    logic [2:0] rnd3;
    logic [7:0] keys;
    logic       rnd_req, game_over;
    logic [7:0] mole, score;
    logic [3:0] miss;

    int n_checks = 0;
    int n_fail   = 0;

    mole_scheduler #(.HOLD_TICKS(3), .GAP_TICKS(2), .MAX_MISS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .rnd3      (rnd3),
        .keys      (keys),
        .rnd_req   (rnd_req),
        .mole      (mole),
        .score     (score),
        .miss      (miss),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tk;
        logic       st;
        logic [2:0] rnd;
        logic [7:0] k;
        logic       rr;
        logic [7:0] mo;
        logic [7:0] sc;
        logic [3:0] mi;
        logic       go;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(logic tk, logic st, logic [2:0] rnd, logic [7:0] k, logic rr,
                                logic [7:0] mo, logic [7:0] sc, logic [3:0] mi, logic go);
        vec_t v;
        v.tk = tk; v.st = st; v.rnd = rnd; v.k = k;
        v.rr = rr; v.mo = mo; v.sc = sc; v.mi = mi; v.go = go;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rr, input logic [7:0] mo,
                           input logic [7:0] sc, input logic [3:0] mi, input logic go);
        chk({tag, " rnd_req"}, rnd_req, rr);
        chk({tag, " mole"}, mole, mo);
        chk({tag, " score"}, score, sc);
        chk({tag, " miss"}, miss, mi);
        chk({tag, " game_over"}, game_over, go);
    endtask

    // Drive on the falling edge, sample just after the following rising edge.
    task automatic step(input logic tk, input logic st, input logic [2:0] rnd,
                        input logic [7:0] k);
        @(negedge clk);
        tick = tk; start = st; rnd3 = rnd; keys = k;
        @(posedge clk);
        #1;
    endtask

    task automatic hit_once(input int seed);
        bit seen = 1'b0;
        logic [7:0] lit;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 3'((seed + i) % 8), 8'd0);
            if (rnd_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL hit_once timeout: got no rnd_req, expected one within 20 cycles");
        end
        step(1'b0, 1'b0, 3'd0, 8'd0);
        lit = mole;
        step(1'b0, 1'b0, 3'd0, lit);
    endtask

    initial begin
        //               tk st rnd keys          rr mole          sc    mi go
        vecs[0]  = mk(1, 1, 0, 8'h00,        0, 8'h00,        0, 0, 0);
        vecs[1]  = mk(1, 0, 5, 8'h00,        0, 8'h00,        0, 0, 0);
        vecs[2]  = mk(1, 0, 5, 8'h00,        1, 8'h00,        0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 8'h00,        0, 8'b0010_0000, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 8'b0010_0100, 0, 8'h00,        1, 0, 0);
        vecs[5]  = mk(1, 0, 2, 8'h00,        0, 8'h00,        1, 0, 0);
        vecs[6]  = mk(1, 0, 5, 8'h00,        1, 8'h00,        1, 0, 0);
        vecs[7]  = mk(1, 0, 0, 8'h00,        0, 8'b0100_0000, 1, 0, 0);
        vecs[8]  = mk(1, 0, 0, 8'h80,        0, 8'b0100_0000, 1, 0, 0);
        vecs[9]  = mk(1, 0, 0, 8'h00,        0, 8'h00,        1, 1, 0);
        vecs[10] = mk(1, 1, 0, 8'h00,        0, 8'h00,        1, 1, 0);
        vecs[11] = mk(1, 0, 7, 8'h00,        1, 8'h00,        1, 1, 0);
        vecs[12] = mk(0, 0, 0, 8'h00,        0, 8'h80,        1, 1, 0);
        vecs[13] = mk(1, 1, 0, 8'h7f,        0, 8'h80,        1, 1, 0);
        vecs[14] = mk(1, 0, 0, 8'h00,        0, 8'h80,        1, 1, 0);
        vecs[15] = mk(1, 0, 0, 8'h80,        0, 8'h00,        2, 1, 0);
        vecs[16] = mk(1, 0, 0, 8'h00,        0, 8'h00,        2, 1, 0);
        vecs[17] = mk(1, 0, 7, 8'h00,        1, 8'h00,        2, 1, 0);
        vecs[18] = mk(0, 0, 0, 8'h00,        0, 8'h01,        2, 1, 0);
        vecs[19] = mk(1, 0, 0, 8'h00,        0, 8'h01,        2, 1, 0);
        vecs[20] = mk(1, 0, 0, 8'h00,        0, 8'h01,        2, 1, 0);
        vecs[21] = mk(1, 0, 0, 8'h00,        0, 8'h00,        2, 2, 1);
        vecs[22] = mk(1, 0, 0, 8'h01,        0, 8'h00,        2, 2, 1);
        vecs[23] = mk(1, 1, 0, 8'h00,        0, 8'h00,        0, 0, 0);
        vecs[24] = mk(1, 0, 0, 8'h00,        0, 8'h00,        0, 0, 0);
        vecs[25] = mk(1, 0, 0, 8'h00,        1, 8'h00,        0, 0, 0);
        vecs[26] = mk(0, 0, 0, 8'h00,        0, 8'h02,        0, 0, 0);

        rst = 1'b1; tick = 1'b0; start = 1'b0; rnd3 = 3'd0; keys = 8'd0;
        #1;
        chk_all("reset", 1'b0, 8'd0, 8'd0, 4'd0, 1'b0);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].tk, vecs[i].st, vecs[i].rnd, vecs[i].k);
            chk_all($sformatf("vec%0d", i), vecs[i].rr, vecs[i].mo, vecs[i].sc, vecs[i].mi,
                    vecs[i].go);
        end

        // Asynchronous reset while the mole is lit, away from any clock edge.
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 8'd0, 8'd0, 4'd0, 1'b0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 3'd3, 8'hff);
            chk_all($sformatf("idle_hold%0d", i), 1'b0, 8'd0, 8'd0, 4'd0, 1'b0);
        end

        step(1'b0, 1'b1, 3'd3, 8'd0);
        step(1'b1, 1'b0, 3'd3, 8'd0);
        step(1'b1, 1'b0, 3'd3, 8'd0);
        chk("restart rnd_req", rnd_req, 1);
        step(1'b0, 1'b0, 3'd0, 8'd0);
        chk("restart mole", mole, 8'h08);

        step(1'b0, 1'b0, 3'd0, 8'h08);
        chk("sat hit1 score", score, 1);
        for (int n = 2; n <= 256; n++) begin
            hit_once(n);
            if (n == 200 || n >= 254)
                chk($sformatf("sat hit%0d score", n), score, (n > 255) ? 255 : n);
        end
        chk("sat miss", miss, 0);
        chk("sat game_over", game_over, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter HOLD_TICKS, default 800: number of ticks a mole stays lit; legal range 1..1023.
REQ-002 Parameter GAP_TICKS, default 200: number of dark ticks between moles; legal range 1..1023.
REQ-003 Parameter MAX_MISS, default 5: number of misses that ends the game; legal range 1..15.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port tick, input, 1 bit: 1 ms enable pulse, one clk cycle wide.
REQ-007 Port start, input, 1 bit: start/restart request pulse.
REQ-008 Port rnd3, input, 3 bits: random hole index from the 16-bit LFSR random source.
REQ-009 Port keys, input, 8 bits: debounced single-cycle key pulses; bit i = hole i.
REQ-010 Port rnd_req, output, 1 bit: one-cycle pulse marking the cycle in which rnd3 is consumed.
REQ-011 Port mole, output, 8 bits: one-hot LED drive for the lit hole; all zero when no mole is lit.
REQ-012 Port score, output, 8 bits: hit count.
REQ-013 Port miss, output, 4 bits: miss count.
REQ-014 Port game_over, output, 1 bit: high while in state OVER.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, GAP, SHOW and OVER, and all outputs SHALL be registered.
REQ-016 In IDLE, a start pulse SHALL clear score, miss, the tick counter and last_hole (last_hole cleared to 0), then move to GAP on the next clk.
REQ-017 In GAP, the tick counter SHALL increment only on tick cycles; mole SHALL be 0.
REQ-018 GAP exit: on the tick that makes the counter equal GAP_TICKS:
- rnd_req SHALL be 1 for exactly that cycle.
- hole SHALL be sampled from rnd3; if rnd3 equals last_hole, hole SHALL be (rnd3+1) mod 8.
- last_hole SHALL be set to hole, the counter SHALL be cleared, and the state SHALL go to SHOW.
REQ-019 In SHOW, mole SHALL equal 1<<hole, starting the cycle after the transition into SHOW.
REQ-020 In SHOW, the counter SHALL count tick cycles.
REQ-021 Hit in SHOW: keys[hole]=1 SHALL increment score (saturating at 255), clear the counter and go to GAP.
REQ-022 Key pulses on bits other than hole SHALL be ignored in SHOW, including when they occur in the same cycle as a hit.
REQ-023 Timeout in SHOW: on the tick that makes the counter equal HOLD_TICKS with no hit in that cycle:
- miss SHALL increment.
- If the new miss value equals MAX_MISS, the state SHALL go to OVER; otherwise it SHALL go to GAP with the counter cleared.
REQ-024 A hit and a timeout in the same cycle SHALL be treated as a hit only; miss SHALL be unchanged.
REQ-025 Keys SHALL be ignored in IDLE, GAP and OVER.
REQ-026 In OVER: mole SHALL be 0, game_over SHALL be 1, and score and miss SHALL hold their values.
REQ-027 A start pulse in OVER SHALL behave exactly as a start pulse in IDLE (clear, then GAP).
REQ-028 A start pulse in GAP or SHOW SHALL be ignored.
REQ-029 tick and start asserted in the same cycle in IDLE or OVER: start SHALL take effect and tick SHALL NOT advance the counter.
REQ-030 The tick counter SHALL be 10 bits and SHALL NOT wrap; it is always cleared on a state change.

Reset
REQ-031 While rst=1, and immediately on its assertion, the block SHALL force:
- state = IDLE.
- mole = 0, score = 0, miss = 0, game_over = 0, rnd_req = 0.
- counter = 0, last_hole = 0, hole = 0.
REQ-032 Reset asserted mid-SHOW SHALL extinguish mole asynchronously, without waiting for a clk edge.
REQ-033 After rst deasserts, the block SHALL remain in IDLE until a start pulse arrives.

Verification
REQ-034 Reset, start, GAP_TICKS=2, rnd3=5, two ticks -> rnd_req pulses once; the next cycle mole=8'b0010_0000.
REQ-035 In SHOW with hole=5, keys=8'b0010_0100 -> score=1, miss=0, state GAP, mole=0 the next cycle.
REQ-036 Consecutive samples with rnd3=5 twice -> second hole=6, mole=8'b0100_0000; with last_hole=7 and rnd3=7 -> hole=0.
REQ-037 MAX_MISS=2, HOLD_TICKS=3, no keys -> miss=1, then 2, then game_over=1 and mole=0; a later start -> score=0, miss=0, state GAP.
REQ-038 keys[hole] on the same cycle as the HOLD_TICKS-th tick -> score+1, miss unchanged; score at 255 plus a hit -> score stays 255.
REQ-039 rst pulsed mid-SHOW (mole nonzero) -> mole=0 before the next clk edge and all outputs at reset values.
